// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer
// Owns the front-end program counter and the instruction-memory fetch
// handshake. Steps the PC by PC_STEP on every accepted fetch, applies
// branch/jump redirects, honours stall and halt/resume, and parks in ERROR
// when a request goes unanswered for TIMEOUT requesting cycles.
//
// Optional build macro: PC_ALIGN_CHECK_EN
//   defined   - redirects to a target with nonzero low two bits are rejected
//               and set the sticky misalign_err flag
//   undefined - targets load verbatim, misalign_err is tied low
//
// Ports
//   clk, rst          clock and synchronous active-high reset
//   stall             suppress the fetch request this cycle
//   redirect_valid    load pc from redirect_target
//   redirect_target   branch/jump target
//   halt, resume      enter / leave HALTED
//   imem_req          fetch request (combinational from state and stall)
//   imem_addr         fetch address, always equal to pc
//   imem_ack          memory accepts the fetch at imem_addr this cycle
//   instr_valid       one-cycle pulse: a fetch completed
//   instr_pc          address of the completed fetch
//   pc                current program counter
//   state             IDLE=00, FETCH=01, HALTED=10, ERROR=11
//   fetch_timeout     sticky timeout flag
//   misalign_err      sticky misaligned-redirect flag
//
// state  | meaning
// IDLE   | one cycle after reset, no request, then FETCH
// FETCH  | requesting (unless stalled), pc steps on each accepted fetch
// HALTED | no request, pc held, redirects still load pc, resume -> FETCH
// ERROR  | fetch timed out, everything ignored until rst

module pc_fetch_sequencer #(
    parameter int PC_WIDTH = 8,
    parameter int PC_STEP  = 4,
    parameter int RESET_PC = 0,
    parameter int TIMEOUT  = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                redirect_valid,
    input  logic [PC_WIDTH-1:0] redirect_target,
    input  logic                halt,
    input  logic                resume,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic                imem_ack,
    output logic                instr_valid,
    output logic [PC_WIDTH-1:0] instr_pc,
    output logic [PC_WIDTH-1:0] pc,
    output logic [1:0]          state,
    output logic                fetch_timeout,
    output logic                misalign_err
);

    localparam logic [1:0] S_IDLE   = 2'b00;
    localparam logic [1:0] S_FETCH  = 2'b01;
    localparam logic [1:0] S_HALTED = 2'b10;
    localparam logic [1:0] S_ERROR  = 2'b11;

    localparam logic [PC_WIDTH-1:0] STEP     = PC_WIDTH'(PC_STEP);
    localparam logic [PC_WIDTH-1:0] PC_RESET = PC_WIDTH'(RESET_PC);
    // Terminal count: the TIMEOUT-th unanswered requesting cycle trips ERROR.
    localparam logic [7:0]          WAIT_LAST = 8'(TIMEOUT - 1);

    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [PC_WIDTH-1:0] instr_pc_q, instr_pc_d;
    logic [1:0]          state_q, state_d;
    logic                instr_valid_q, instr_valid_d;
    logic                timeout_q, timeout_d;
    logic [7:0]          wait_q, wait_d;

    logic fetch_accept;
    logic redirect_bad;
    logic redirect_load;

    assign imem_req     = (state_q == S_FETCH) && !stall;
    assign fetch_accept = imem_req && imem_ack;

`ifdef PC_ALIGN_CHECK_EN
    assign redirect_bad = redirect_valid && (redirect_target[1:0] != 2'b00);
`else
    assign redirect_bad = 1'b0;
`endif
    assign redirect_load = redirect_valid && !redirect_bad;

    always_comb begin
        pc_d          = pc_q;
        instr_pc_d    = instr_pc_q;
        state_d       = state_q;
        instr_valid_d = 1'b0;
        timeout_d     = timeout_q;
        wait_d        = wait_q;
        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
                if (redirect_load) pc_d = redirect_target;
            end
            S_FETCH: begin
                if (redirect_valid) begin
                    // Redirect wins over a same-cycle ack; that fetch is dropped.
                    wait_d = 8'd0;
                    if (redirect_load) pc_d = redirect_target;
                end else if (fetch_accept) begin
                    instr_valid_d = 1'b1;
                    instr_pc_d    = pc_q;
                    pc_d          = pc_q + STEP;
                    wait_d        = 8'd0;
                    if (halt) state_d = S_HALTED;
                end else if (imem_req && (wait_q == WAIT_LAST)) begin
                    timeout_d = 1'b1;
                    state_d   = S_ERROR;
                    wait_d    = 8'd0;
                end else begin
                    // Stalled cycles hold the count.
                    if (imem_req) wait_d = wait_q + 8'd1;
                    if (halt) begin
                        state_d = S_HALTED;
                        wait_d  = 8'd0;
                    end
                end
            end
            S_HALTED: begin
                if (redirect_load) pc_d = redirect_target;
                if (resume && !halt) state_d = S_FETCH;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= PC_RESET;
            instr_pc_q    <= '0;
            state_q       <= S_IDLE;
            instr_valid_q <= 1'b0;
            timeout_q     <= 1'b0;
            wait_q        <= 8'd0;
        end else begin
            pc_q          <= pc_d;
            instr_pc_q    <= instr_pc_d;
            state_q       <= state_d;
            instr_valid_q <= instr_valid_d;
            timeout_q     <= timeout_d;
            wait_q        <= wait_d;
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    logic misalign_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_q <= 1'b0;
        end else if (redirect_bad && (state_q != S_ERROR)) begin
            misalign_q <= 1'b1;
        end
    end
    assign misalign_err = misalign_q;
`else
    assign misalign_err = 1'b0;
`endif

    assign imem_addr     = pc_q;
    assign pc            = pc_q;
    assign instr_pc      = instr_pc_q;
    assign instr_valid   = instr_valid_q;
    assign state         = state_q;
    assign fetch_timeout = timeout_q;

endmodule
